// File: rtl/a25_wishbone_slave_buf_pkg.sv
// Shared types and constants for the Amber 128-bit Wishbone responder
// and its posted-write buffer.
package a25_wishbone_slave_buf_pkg;

  localparam int WB_DW = 128;
  localparam int WB_SW = 16;
  localparam int WB_AW = 32;
  localparam logic [WB_SW-1:0] BE_ALL = 16'hffff;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ACK   = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_ACK   = 3'd5,
    ST_RD_ERR   = 3'd6
  } state_e;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] wdata;
    logic [WB_SW-1:0] be;
  } wbuf_entry_t;

endpackage

// File: rtl/a25_wb_wbuf_fifo.sv
// Two-entry posted-write buffer. Push and pop may coincide; the caller
// guarantees no push into a full buffer unless a pop happens in the same cycle.
module a25_wb_wbuf_fifo
  import a25_wishbone_slave_buf_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  wbuf_entry_t push_data_i,
  input  logic        pop_i,
  output wbuf_entry_t head_o,
  output logic [1:0]  count_o
);

  wbuf_entry_t mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_i;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/a25_wishbone_slave_buf.sv
// Wishbone B3 classic responder: posts writes into a 2-entry buffer with
// early ack; reads drain the buffer first, then wait for data with a timeout.
module a25_wishbone_slave_buf
  import a25_wishbone_slave_buf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [WB_AW-1:0]  i_wb_adr,
  input  logic [WB_SW-1:0]  i_wb_sel,
  input  logic [WB_DW-1:0]  i_wb_dat,
  output logic [WB_DW-1:0]  o_wb_dat,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic              o_mem_valid,
  input  logic              i_mem_accepted,
  output logic              o_mem_write,
  output logic [WB_AW-1:0]  o_mem_addr,
  output logic [WB_DW-1:0]  o_mem_wdata,
  output logic [WB_SW-1:0]  o_mem_be,
  input  logic [WB_DW-1:0]  i_mem_rdata,
  input  logic              i_mem_rdata_valid,
  output logic [2:0]        o_dbg_state,
  output logic [1:0]        o_dbg_count
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [WB_AW-1:0] rd_addr_q, rd_addr_d;
  logic [WB_DW-1:0] rdat_q, rdat_d;

  wbuf_entry_t head, push_entry;
  logic [1:0]  count;
  logic        req, wr_valid, pop, can_push, push;

  // Handshake: a request transfers on a cycle where o_mem_valid and
  // i_mem_accepted are both high; outputs hold steady while valid is waiting.
  assign req        = i_wb_cyc & i_wb_stb;
  assign wr_valid   = (count != 2'd0) && (state_q != ST_RD_REQ);
  assign pop        = wr_valid & i_mem_accepted;
  assign can_push   = (count != 2'd2) | pop;
  assign push       = (state_q == ST_IDLE) & req & i_wb_we & can_push;
  assign push_entry = '{addr: i_wb_adr - MEM_BASE, wdata: i_wb_dat, be: i_wb_sel};

  a25_wb_wbuf_fifo u_wbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    rd_addr_d = rd_addr_q;
    rdat_d    = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (i_wb_we) begin
            if (can_push) state_d = ST_WR_ACK;
          end else begin
            rd_addr_d = i_wb_adr - MEM_BASE;
            state_d   = ST_RD_DRAIN;
          end
        end
      end
      ST_WR_ACK: state_d = ST_IDLE;
      ST_RD_DRAIN: begin
        if (!i_wb_cyc)            state_d = ST_IDLE;
        else if (count == 2'd0)   state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        // An accept in the same cycle as cyc dropping still commits the read.
        if (i_mem_accepted) begin
          state_d = ST_RD_WAIT;
          tmo_d   = 8'd0;
        end else if (!i_wb_cyc) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (i_mem_rdata_valid) begin
          rdat_d  = i_mem_rdata;
          state_d = i_wb_cyc ? ST_RD_ACK : ST_IDLE;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = ST_RD_ERR;
        end else if (tmo_q != 8'hff) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RD_ACK: state_d = ST_IDLE;
      ST_RD_ERR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= 8'd0;
      rd_addr_q <= '0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      rd_addr_q <= rd_addr_d;
      rdat_q    <= rdat_d;
    end
  end

  always_comb begin
    o_mem_valid = wr_valid;
    o_mem_write = 1'b1;
    o_mem_addr  = head.addr;
    o_mem_wdata = head.wdata;
    o_mem_be    = head.be;
    if (state_q == ST_RD_REQ) begin
      o_mem_valid = 1'b1;
      o_mem_write = 1'b0;
      o_mem_addr  = rd_addr_q;
      o_mem_wdata = '0;
      o_mem_be    = BE_ALL;
    end
  end

  assign o_wb_ack    = (state_q == ST_WR_ACK) || (state_q == ST_RD_ACK);
  assign o_wb_err    = (state_q == ST_RD_ERR);
  assign o_wb_dat    = rdat_q;
  assign o_dbg_state = state_q;
  assign o_dbg_count = count;

endmodule

// File: tb/tb_a25_wishbone_slave_buf.sv
// Directed bench for a25_wishbone_slave_buf: posted writes, buffer-full stall,
// read ordering behind writes, read timeout, abandoned read and async reset.
module tb_a25_wishbone_slave_buf;
  import a25_wishbone_slave_buf_pkg::*;

  logic         clk, reset_n;
  logic         i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]  i_wb_adr;
  logic [15:0]  i_wb_sel;
  logic [127:0] i_wb_dat, o_wb_dat;
  logic         o_wb_ack, o_wb_err;
  logic         o_mem_valid, i_mem_accepted, o_mem_write;
  logic [31:0]  o_mem_addr;
  logic [127:0] o_mem_wdata, i_mem_rdata;
  logic [15:0]  o_mem_be;
  logic         i_mem_rdata_valid;
  logic [2:0]   o_dbg_state;
  logic [1:0]   o_dbg_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];

  a25_wishbone_slave_buf #(.TIMEOUT_CYCLES(4), .MEM_BASE(32'h0)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_wb_cyc          (i_wb_cyc),
    .i_wb_stb          (i_wb_stb),
    .i_wb_we           (i_wb_we),
    .i_wb_adr          (i_wb_adr),
    .i_wb_sel          (i_wb_sel),
    .i_wb_dat          (i_wb_dat),
    .o_wb_dat          (o_wb_dat),
    .o_wb_ack          (o_wb_ack),
    .o_wb_err          (o_wb_err),
    .o_mem_valid       (o_mem_valid),
    .i_mem_accepted    (i_mem_accepted),
    .o_mem_write       (o_mem_write),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .o_mem_be          (o_mem_be),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_rdata_valid (i_mem_rdata_valid),
    .o_dbg_state       (o_dbg_state),
    .o_dbg_count       (o_dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Records every write the memory side takes, in order.
  always @(posedge clk) begin
    if (reset_n && o_mem_valid && i_mem_accepted && o_mem_write)
      acc_q.push_back(o_mem_addr);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat, output bit acked);
    acked = 1'b0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = adr; i_wb_sel = sel; i_wb_dat = dat;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_wb_ack) begin
        acked = 1'b1;
        break;
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read_start(input logic [31:0] adr);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = adr;
  endtask

  task automatic wait_rd_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_mem_valid && !o_mem_write) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_len"}, acc_q.size(), exp_q.size());
    while (exp_q.size() > 0 && acc_q.size() > 0)
      check({tag, "_addr"}, acc_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    bit ok;
    int n;
    reset_n = 1'b0;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = '0; i_wb_sel = '0; i_wb_dat = '0;
    i_mem_accepted = 0; i_mem_rdata = '0; i_mem_rdata_valid = 0;
    repeat (2) tick();
    check("rst_ack", o_wb_ack, 0);
    check("rst_err", o_wb_err, 0);
    check("rst_dat", o_wb_dat, 0);
    check("rst_valid", o_mem_valid, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    check("rst_count", o_dbg_count, 0);
    reset_n = 1'b1;
    tick();

    // Single posted write, memory accepting.
    i_mem_accepted = 1'b1;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1;
    i_wb_adr = 32'h100; i_wb_sel = 16'h000f; i_wb_dat = 128'hA5;
    #1 check("w1_noack_early", o_wb_ack, 0);
    tick();
    check("w1_ack", o_wb_ack, 1);
    check("w1_count", o_dbg_count, 1);
    check("w1_valid", o_mem_valid, 1);
    check("w1_write", o_mem_write, 1);
    check("w1_addr", o_mem_addr, 32'h100);
    check("w1_be", o_mem_be, 16'h000f);
    check("w1_wdata", o_mem_wdata, 128'hA5);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    tick();
    check("w1_ack_off", o_wb_ack, 0);
    check("w1_drained", o_dbg_count, 0);
    exp_q.push_back(32'h100);
    check_sb("w1_sb");

    // Three writes with memory stalled: third waits for a free slot.
    i_mem_accepted = 1'b0;
    wb_write(32'h10, 16'hffff, 128'h1, ok); check("w3a_acked", ok, 1);
    wb_write(32'h20, 16'hffff, 128'h2, ok); check("w3b_acked", ok, 1);
    check("w3_full", o_dbg_count, 2);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_adr = 32'h30; i_wb_dat = 128'h3;
    n = 0;
    repeat (4) begin
      tick();
      if (o_wb_ack) n++;
    end
    check("w3c_stall_noack", n, 0);
    check("w3c_stall_head", o_mem_addr, 32'h10);
    i_mem_accepted = 1'b1;
    tick();
    check("w3c_ack_on_pop", o_wb_ack, 1);
    check("w3c_count_same", o_dbg_count, 2);
    check("w3c_head_next", o_mem_addr, 32'h20);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    tick(); tick();
    check("w3_drained", o_dbg_count, 0);
    exp_q.push_back(32'h10); exp_q.push_back(32'h20); exp_q.push_back(32'h30);
    check_sb("w3_sb");

    // Read behind two buffered writes.
    i_mem_accepted = 1'b0;
    wb_write(32'h40, 16'h00ff, 128'h4, ok); check("rd_w1_acked", ok, 1);
    wb_write(32'h50, 16'hff00, 128'h5, ok); check("rd_w2_acked", ok, 1);
    wb_read_start(32'h200);
    repeat (3) tick();
    check("rd_draining", o_dbg_state, ST_RD_DRAIN);
    check("rd_still_write", o_mem_write, 1);
    check("rd_head", o_mem_addr, 32'h40);
    i_mem_accepted = 1'b1;
    wait_rd_req(ok);
    check("rd_req_seen", ok, 1);
    check("rd_req_addr", o_mem_addr, 32'h200);
    check("rd_req_be", o_mem_be, 16'hffff);
    check("rd_req_count", o_dbg_count, 0);
    tick();
    i_mem_accepted = 1'b0;
    check("rd_wait", o_dbg_state, ST_RD_WAIT);
    tick(); tick();
    i_mem_rdata = 128'hDEAD; i_mem_rdata_valid = 1'b1;
    tick();
    i_mem_rdata_valid = 1'b0;
    check("rd_ack", o_wb_ack, 1);
    check("rd_noerr", o_wb_err, 0);
    check("rd_dat", o_wb_dat, 128'hDEAD);
    i_wb_cyc = 0; i_wb_stb = 0;
    tick();
    check("rd_ack_pulse", o_wb_ack, 0);
    check("rd_idle", o_dbg_state, ST_IDLE);
    exp_q.push_back(32'h40); exp_q.push_back(32'h50);
    check_sb("rd_sb");

    // Read timeout with TIMEOUT_CYCLES=4.
    i_mem_accepted = 1'b1;
    wb_read_start(32'h300);
    wait_rd_req(ok);
    check("to_req_seen", ok, 1);
    tick();
    i_mem_accepted = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (o_wb_err) begin
        n = i;
        break;
      end
    end
    check("to_err_cycles", n, 4);
    check("to_noack", o_wb_ack, 0);
    check("to_dat_kept", o_wb_dat, 128'hDEAD);
    i_wb_cyc = 0; i_wb_stb = 0;
    tick();
    check("to_err_pulse", o_wb_err, 0);
    check("to_idle", o_dbg_state, ST_IDLE);

    // Abandoned read: data still captured, no termination.
    i_mem_accepted = 1'b1;
    wb_read_start(32'h400);
    wait_rd_req(ok);
    check("ab_req_seen", ok, 1);
    tick();
    i_mem_accepted = 1'b0;
    i_wb_cyc = 0; i_wb_stb = 0;
    tick(); tick();
    i_mem_rdata = 128'hBEEF; i_mem_rdata_valid = 1'b1;
    tick();
    i_mem_rdata_valid = 1'b0;
    check("ab_idle", o_dbg_state, ST_IDLE);
    check("ab_dat", o_wb_dat, 128'hBEEF);
    check("ab_noack", o_wb_ack, 0);
    check("ab_noerr", o_wb_err, 0);
    i_mem_rdata = 128'h1234; i_mem_rdata_valid = 1'b1;
    tick();
    i_mem_rdata_valid = 1'b0;
    check("stray_rdata_ignored", o_wb_dat, 128'hBEEF);
    i_mem_accepted = 1'b1;
    wb_write(32'h500, 16'h0001, 128'h55, ok);
    check("ab_write_acked", ok, 1);
    tick();
    exp_q.push_back(32'h500);
    check_sb("ab_sb");

    // Asynchronous reset while waiting for read data.
    wb_read_start(32'h600);
    wait_rd_req(ok);
    check("rst_req_seen", ok, 1);
    tick();
    i_mem_accepted = 1'b0;
    check("rst_in_wait", o_dbg_state, ST_RD_WAIT);
    #2 reset_n = 1'b0;
    #1;
    check("arst_dat", o_wb_dat, 0);
    check("arst_valid", o_mem_valid, 0);
    check("arst_ack", o_wb_ack, 0);
    check("arst_err", o_wb_err, 0);
    check("arst_state", o_dbg_state, ST_IDLE);
    check("arst_count", o_dbg_count, 0);
    i_wb_cyc = 0; i_wb_stb = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check_sb("end_sb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
